// File: rtl/multi_port_result_checker_if.sv
// Snooped CPU data-memory write bus plus the expected-value load port of the result checker.
interface multi_port_result_checker_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int CH_W   = 2,
  parameter int IDX_W  = 6
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wen;
  logic              ld_en;
  logic [CH_W-1:0]   ld_ch;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;

  modport master (output addr, data, wen, ld_en, ld_ch, ld_idx, ld_data);
  modport slave  (input  addr, data, wen, ld_en, ld_ch, ld_idx, ld_data);
endinterface

// File: rtl/multi_port_result_checker.sv
// Snoops data-memory writes to NUM_CH test ports and compares them against runtime-loaded
// expected sequences; reports errors, run length, per-channel completion and watchdog expiry.
module multi_port_result_checker #(
  parameter int                NUM_CH      = 4,
  parameter int                ADDR_W      = 30,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 64,
  parameter logic [ADDR_W-1:0] PORT_BASE   = 30'h40,
  parameter logic [ADDR_W-1:0] PORT_STRIDE = 30'h1,
  parameter logic [DATA_W-1:0] BEGIN_SYM   = 32'h932,
  parameter logic [DATA_W-1:0] END_SYM     = 32'hD5D,
  parameter logic [15:0]       TIMEOUT     = 16'hFFFF,
  parameter int                ERR_W       = 8,
  localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int               IDX_W       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  multi_port_result_checker_if.slave   bus,
  output logic [ERR_W-1:0]             error_num,
  output logic [15:0]                  duration,
  output logic                         finish,
  output logic                         timeout,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [CH_W-1:0]              first_err_ch,
  output logic [IDX_W-1:0]             first_err_idx
);
  // Storage is sized to the full channel-index range so any decoded index is in bounds.
  localparam int CH_SLOTS = 2 ** CH_W;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_REPORT} state_e;

  state_e            state_q, state_d;
  logic              wen_q;
  logic              accepted;
  logic              hit;
  logic [CH_W-1:0]   hit_ch;
  logic [DATA_W-1:0] mem [CH_SLOTS][DEPTH];
  logic [IDX_W-1:0]  ptr_q [CH_SLOTS];
  logic [CH_SLOTS-1:0] done_q;
  logic [IDX_W-1:0]  cur_ptr;
  logic [DATA_W-1:0] exp_word;
  logic              cur_done;
  logic              all_done;
  logic              wd_expired;
  logic              start_run;
  logic              check_wr;
  logic              mismatch;
  logic              overrun;

  // One check per wen-high run, so a stalled store is never checked twice.
  assign accepted = bus.wen & ~wen_q;

  // NOTE: every variable of an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.addr == ADDR_W'(PORT_BASE + ADDR_W'(k) * PORT_STRIDE)) begin
        hit    = 1'b1;
        hit_ch = CH_W'(k);
      end
    end
  end

  assign cur_ptr    = ptr_q[hit_ch];
  assign exp_word   = mem[hit_ch][cur_ptr];
  assign cur_done   = done_q[hit_ch];
  assign all_done   = &done_q[NUM_CH-1:0];
  assign wd_expired = (duration == TIMEOUT);
  assign start_run  = (state_q == ST_IDLE) && accepted && hit && (hit_ch == '0) &&
                      (bus.data == BEGIN_SYM);
  assign check_wr   = (state_q == ST_CHECK) && accepted && hit;
  assign mismatch   = check_wr && !cur_done && (bus.data != exp_word);
  assign overrun    = check_wr && cur_done;

  assign ch_done = done_q[NUM_CH-1:0];
  assign finish  = (state_q == ST_REPORT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_run) state_d = ST_CHECK;
      ST_CHECK:  if (all_done || wd_expired) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_REPORT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q         <= 1'b0;
      error_num     <= '1;
      duration      <= '0;
      timeout       <= 1'b0;
      done_q        <= '0;
      first_err_ch  <= '0;
      first_err_idx <= '0;
      for (int k = 0; k < CH_SLOTS; k++) ptr_q[k] <= '0;
    end else begin
      wen_q <= bus.wen;
      case (state_q)
        ST_IDLE: begin
          if (start_run) begin
            error_num <= '0;
            duration  <= '0;
            done_q    <= '0;
            for (int k = 0; k < CH_SLOTS; k++) ptr_q[k] <= '0;
          end
        end
        ST_CHECK: begin
          // Duration freezes on the exit cycle so REPORT shows the value that triggered it.
          if (state_d == ST_REPORT) timeout <= wd_expired && !all_done;
          else if (duration != '1)  duration <= duration + 1'b1;

          if ((mismatch || overrun) && (error_num != '1)) error_num <= error_num + 1'b1;
          if (mismatch && (error_num == '0)) begin
            first_err_ch  <= hit_ch;
            first_err_idx <= cur_ptr;
          end
          if (check_wr && !cur_done) begin
            ptr_q[hit_ch] <= cur_ptr + 1'b1;
            if ((exp_word == END_SYM) || (cur_ptr == IDX_W'(DEPTH - 1))) done_q[hit_ch] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the expected memory has no reset on purpose; loaded sequences survive a reset.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && bus.ld_en) mem[bus.ld_ch][bus.ld_idx] <= bus.ld_data;
  end
endmodule

// File: tb/tb_multi_port_result_checker.sv
// Directed bench: a single-channel checker (Fibonacci runs, stalls, mid-run reset) and a
// two-channel checker (mismatch, overrun, watchdog timeout with TIMEOUT=100).
module tb_multi_port_result_checker;
  localparam logic [31:0] BEGIN_SYM = 32'h932;
  localparam logic [31:0] END_SYM   = 32'hD5D;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  multi_port_result_checker_if #(.ADDR_W(30), .DATA_W(32), .CH_W(1), .IDX_W(6)) bus_a ();
  multi_port_result_checker_if #(.ADDR_W(30), .DATA_W(32), .CH_W(1), .IDX_W(6)) bus_b ();

  logic [7:0]  error_num_a, error_num_b;
  logic [15:0] duration_a, duration_b;
  logic        finish_a, finish_b, timeout_a, timeout_b;
  logic [0:0]  ch_done_a;
  logic [1:0]  ch_done_b;
  logic [0:0]  first_err_ch_a, first_err_ch_b;
  logic [5:0]  first_err_idx_a, first_err_idx_b;

  multi_port_result_checker #(.NUM_CH(1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a.slave),
    .error_num(error_num_a), .duration(duration_a), .finish(finish_a), .timeout(timeout_a),
    .ch_done(ch_done_a), .first_err_ch(first_err_ch_a), .first_err_idx(first_err_idx_a)
  );

  multi_port_result_checker #(.NUM_CH(2), .TIMEOUT(16'd100)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.slave),
    .error_num(error_num_b), .duration(duration_b), .finish(finish_b), .timeout(timeout_b),
    .ch_done(ch_done_b), .first_err_ch(first_err_ch_b), .first_err_idx(first_err_idx_b)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] fib [33];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [29:0] a, input logic [31:0] d, input int hold);
    @(posedge clk); #1;
    bus_a.addr = a; bus_a.data = d; bus_a.wen = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus_a.wen = 1'b0;
  endtask

  task automatic wr_b(input logic [29:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus_b.addr = a; bus_b.data = d; bus_b.wen = 1'b1;
    @(posedge clk);
    #1 bus_b.wen = 1'b0;
  endtask

  task automatic ld_a(input logic [5:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    bus_a.ld_en = 1'b1; bus_a.ld_ch = 1'b0; bus_a.ld_idx = idx; bus_a.ld_data = d;
  endtask

  task automatic ld_b(input logic ch, input logic [5:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    bus_b.ld_en = 1'b1; bus_b.ld_ch = ch; bus_b.ld_idx = idx; bus_b.ld_data = d;
  endtask

  task automatic wait_finish_a(input int budget);
    int n = 0;
    while (finish_a !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
  endtask

  task automatic wait_finish_b(input int budget);
    int n = 0;
    while (finish_b !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
  endtask

  task automatic fib_run_a(input int hold);
    wr_a(30'h40, BEGIN_SYM, hold);
    for (int i = 0; i < 33; i++) wr_a(30'h40, fib[i], hold);
    wait_finish_a(300);
  endtask

  initial begin
    fib[0] = 32'd0;
    fib[1] = 32'd1;
    for (int i = 2; i < 16; i++) fib[i] = fib[i-1] + fib[i-2];
    for (int j = 0; j < 16; j++) fib[16+j] = fib[15-j];
    fib[32] = END_SYM;

    bus_a.addr = '0; bus_a.data = '0; bus_a.wen = 1'b0;
    bus_a.ld_en = 1'b0; bus_a.ld_ch = '0; bus_a.ld_idx = '0; bus_a.ld_data = '0;
    bus_b.addr = '0; bus_b.data = '0; bus_b.wen = 1'b0;
    bus_b.ld_en = 1'b0; bus_b.ld_ch = '0; bus_b.ld_idx = '0; bus_b.ld_data = '0;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst error_num", error_num_a, 8'hFF);
    check("rst duration", duration_a, 16'd0);
    check("rst finish", finish_a, 1'b0);
    check("rst timeout", timeout_a, 1'b0);
    check("rst ch_done", ch_done_a, 1'b0);
    check("rst first_err_idx", first_err_idx_a, 6'd0);
    check("rst b error_num", error_num_b, 8'hFF);
    @(negedge clk) begin rst_a = 1'b1; rst_b = 1'b1; end

    // Single channel, 1-cycle writes: BEGIN at B, write i at B+2+2i, exit at B+67 -> duration 66.
    for (int i = 0; i < 33; i++) ld_a(6'(i), fib[i]);
    @(posedge clk); #1 bus_a.ld_en = 1'b0;
    check("idle error_num", error_num_a, 8'hFF);
    fib_run_a(1);
    check("t1 finish", finish_a, 1'b1);
    check("t1 error_num", error_num_a, 8'd0);
    check("t1 ch_done", ch_done_a, 1'b1);
    check("t1 timeout", timeout_a, 1'b0);
    check("t1 duration", duration_a, 16'd66);
    wr_a(30'h40, 32'h1234, 1);
    check("t1 report frozen err", error_num_a, 8'd0);
    check("t1 report frozen dur", duration_a, 16'd66);

    // Stalled writes (wen high 3 cycles): period 4, last check at B+132 -> duration 132.
    @(negedge clk) rst_a = 1'b0;
    @(negedge clk) rst_a = 1'b1;
    fib_run_a(3);
    check("t2 finish", finish_a, 1'b1);
    check("t2 error_num", error_num_a, 8'd0);
    check("t2 ch_done", ch_done_a, 1'b1);
    check("t2 duration", duration_a, 16'd132);

    // Reset mid-CHECK; a load attempted during CHECK must be ignored.
    @(negedge clk) rst_a = 1'b0;
    @(negedge clk) rst_a = 1'b1;
    wr_a(30'h40, BEGIN_SYM, 1);
    for (int i = 0; i < 10; i++) wr_a(30'h40, fib[i], 1);
    check("t6 mid error_num", error_num_a, 8'd0);
    check("t6 mid duration", duration_a, 16'd20);
    check("t6 mid ch_done", ch_done_a, 1'b0);
    ld_a(6'd3, 32'hDEAD);
    @(posedge clk); #1 bus_a.ld_en = 1'b0;
    @(negedge clk) rst_a = 1'b0;
    #1;
    check("t6 rst error_num", error_num_a, 8'hFF);
    check("t6 rst duration", duration_a, 16'd0);
    check("t6 rst finish", finish_a, 1'b0);
    @(negedge clk) rst_a = 1'b1;
    fib_run_a(1);
    check("t6 finish", finish_a, 1'b1);
    check("t6 error_num", error_num_a, 8'd0);
    check("t6 duration", duration_a, 16'd66);

    // Two channels: ch0 = 100,101,102,END ; ch1 = 200..207,END.
    for (int i = 0; i < 3; i++) ld_b(1'b0, 6'(i), 32'h100 + i);
    ld_b(1'b0, 6'd3, END_SYM);
    for (int i = 0; i < 8; i++) ld_b(1'b1, 6'(i), 32'h200 + i);
    ld_b(1'b1, 6'd8, END_SYM);
    @(posedge clk); #1 bus_b.ld_en = 1'b0;

    wr_b(30'h40, BEGIN_SYM);
    for (int i = 0; i < 3; i++) begin
      wr_b(30'h40, 32'h100 + i);
      wr_b(30'h41, 32'h200 + i);
    end
    wr_b(30'h40, END_SYM);
    check("t3 ch0 done", ch_done_b, 2'b01);
    wr_b(30'h42, 32'h123);
    wr_b(30'h3F, 32'h55);
    check("t3 unmapped ignored", error_num_b, 8'd0);
    wr_b(30'h41, 32'h203);
    wr_b(30'h41, 32'h204);
    wr_b(30'h41, 32'hBAD);
    check("t3 error_num", error_num_b, 8'd1);
    check("t3 first_err_ch", first_err_ch_b, 1'b1);
    check("t3 first_err_idx", first_err_idx_b, 6'd5);
    wr_b(30'h40, 32'h999);
    check("t4 overrun error_num", error_num_b, 8'd2);
    check("t4 overrun ch_done", ch_done_b, 2'b01);
    wr_b(30'h41, 32'h206);
    wr_b(30'h41, 32'h207);
    wr_b(30'h41, END_SYM);
    wait_finish_b(50);
    check("t4 finish", finish_b, 1'b1);
    check("t4 error_num", error_num_b, 8'd2);
    check("t4 ch_done", ch_done_b, 2'b11);
    check("t4 timeout", timeout_b, 1'b0);
    check("t4 first_err_idx", first_err_idx_b, 6'd5);

    // Watchdog: only ch0 completes; REPORT entered with duration frozen at TIMEOUT.
    @(negedge clk) rst_b = 1'b0;
    @(negedge clk) rst_b = 1'b1;
    wr_b(30'h41, BEGIN_SYM);
    wr_b(30'h40, 32'h931);
    check("t5 no false begin", error_num_b, 8'hFF);
    wr_b(30'h40, BEGIN_SYM);
    check("t5 begin clears err", error_num_b, 8'd0);
    for (int i = 0; i < 3; i++) wr_b(30'h40, 32'h100 + i);
    wr_b(30'h40, END_SYM);
    wr_b(30'h41, 32'h200);
    wr_b(30'h41, 32'h201);
    wait_finish_b(300);
    check("t5 finish", finish_b, 1'b1);
    check("t5 timeout", timeout_b, 1'b1);
    check("t5 duration", duration_b, 16'd100);
    check("t5 ch_done", ch_done_b, 2'b01);
    check("t5 error_num", error_num_b, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
